// File: rtl/button_debouncer_pkg.sv
// Shared constants for the push-button debouncer: default channel count,
// debounce window and synchroniser depth.
package button_debouncer_pkg;

    localparam int DEFAULT_NUM_BUTTONS     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;  // 10 ms at 50 MHz
    localparam int DEFAULT_SYNC_STAGES     = 2;

    // Counter must hold DEBOUNCE_CYCLES-1 without wrapping.
    function automatic int debounce_cnt_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Button bus between the board pins / consumers (master) and the debouncer (slave).
interface button_debouncer_if #(
    parameter int NUM_BUTTONS = 2
);

    logic [NUM_BUTTONS-1:0] btn_raw;
    logic [NUM_BUTTONS-1:0] btn_level;
    logic [NUM_BUTTONS-1:0] btn_press;
    logic [NUM_BUTTONS-1:0] btn_release;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release
    );

endinterface

// File: rtl/button_debouncer_debounce_channel.sv
// One button channel: synchroniser chain, stability counter, and registered
// debounced level with one-cycle press/release pulses.
module debounce_channel
    import button_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int                CNT_W    = debounce_cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   sync_s;
    logic [CNT_W-1:0]       cnt_p1;
    logic                   level_p1;
    logic                   press_p1;
    logic                   release_p1;

    // Stage 0: metastability chain into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], btn_in};
        end
    end

    assign sync_s = sync_p0[SYNC_STAGES-1];

    // Stage 1: stability counter; any agreement with the accepted level restarts the window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p1     <= '0;
            level_p1   <= 1'b0;
            press_p1   <= 1'b0;
            release_p1 <= 1'b0;
        end else begin
            press_p1   <= 1'b0;
            release_p1 <= 1'b0;
            if (sync_s == level_p1) begin
                cnt_p1 <= '0;
            end else if (cnt_p1 == CNT_LAST) begin
                cnt_p1     <= '0;
                level_p1   <= sync_s;
                press_p1   <= sync_s;
                release_p1 <= ~sync_s;
            end else begin
                cnt_p1 <= cnt_p1 + CNT_W'(1);
            end
        end
    end

    assign btn_level   = level_p1;
    assign btn_press   = press_p1;
    assign btn_release = release_p1;

endmodule

// File: rtl/button_debouncer.sv
// Debouncer top: optional pin inversion, then one independent debounce
// channel per button, outputs assembled onto the button bus.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int NUM_BUTTONS     = DEFAULT_NUM_BUTTONS,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int ACTIVE_LOW_IN   = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    button_debouncer_if.slave   btn
);

    logic [NUM_BUTTONS-1:0] btn_cond;
    logic [NUM_BUTTONS-1:0] level_bus;
    logic [NUM_BUTTONS-1:0] press_bus;
    logic [NUM_BUTTONS-1:0] release_bus;

    // Normalise so that 1 always means pressed from here on.
    assign btn_cond = (ACTIVE_LOW_IN != 0) ? ~btn.btn_raw : btn.btn_raw;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .btn_in      (btn_cond[i]),
            .btn_level   (level_bus[i]),
            .btn_press   (press_bus[i]),
            .btn_release (release_bus[i])
        );
    end

    assign btn.btn_level   = level_bus;
    assign btn.btn_press   = press_bus;
    assign btn.btn_release = release_bus;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios plus random pin activity,
// with a sample-history reference model checked every cycle.
module tb_button_debouncer;

    localparam int NB = 2;
    localparam int DC = 8;
    localparam int SY = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    button_debouncer_if #(.NUM_BUTTONS(NB)) btn ();

    button_debouncer #(
        .NUM_BUTTONS     (NB),
        .DEBOUNCE_CYCLES (DC),
        .SYNC_STAGES     (SY),
        .ACTIVE_LOW_IN   (0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: s at an edge is the pin value sampled SY edges earlier (0 right
    // after reset); a change is accepted when the last DC values of s all
    // disagree with the current level.
    bit           rawq [NB][$];
    bit           sq   [NB][$];
    bit [NB-1:0]  m_lvl, m_press, m_rel;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NB; c++) begin
                rawq[c].delete();
                sq[c].delete();
            end
            m_lvl   = '0;
            m_press = '0;
            m_rel   = '0;
        end else begin
            for (int c = 0; c < NB; c++) begin
                bit s, acc;
                rawq[c].push_back(btn.btn_raw[c]);
                s = (rawq[c].size() > SY) ? rawq[c][rawq[c].size()-1-SY] : 1'b0;
                sq[c].push_back(s);
                acc = (sq[c].size() >= DC);
                for (int k = 0; k < DC; k++)
                    if (acc && sq[c][sq[c].size()-1-k] == m_lvl[c]) acc = 1'b0;
                m_press[c] = acc && s;
                m_rel[c]   = acc && !s;
                if (acc) m_lvl[c] = s;
                if (rawq[c].size() > 32) void'(rawq[c].pop_front());
                if (sq[c].size() > 32) void'(sq[c].pop_front());
            end
        end
        #1;
        check("model_level",   btn.btn_level,   m_lvl);
        check("model_press",   btn.btn_press,   m_press);
        check("model_release", btn.btn_release, m_rel);
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [NB-1:0] v);
        @(negedge clk);
        btn.btn_raw = v;
    endtask

    int pulses;

    initial begin
        btn.btn_raw = 2'b11;
        #1 rst_n = 1'b0;

        // 1: held buttons through reset
        edges(2);
        check("rst_level",   btn.btn_level,   2'b00);
        check("rst_press",   btn.btn_press,   2'b00);
        check("rst_release", btn.btn_release, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        edges(9);
        check("t1_level_early", btn.btn_level, 2'b00);
        edges(1);
        check("t1_level", btn.btn_level, 2'b11);
        check("t1_press", btn.btn_press, 2'b11);
        edges(1);
        check("t1_press_end", btn.btn_press, 2'b00);

        // 2: clean press on ch0
        drive(2'b10);
        edges(12);
        check("t2_prep_level", btn.btn_level, 2'b10);
        drive(2'b11);
        edges(9);
        check("t2_level_early", btn.btn_level, 2'b10);
        edges(1);
        check("t2_level",   btn.btn_level,   2'b11);
        check("t2_press",   btn.btn_press,   2'b01);
        check("t2_release", btn.btn_release, 2'b00);
        edges(1);
        check("t2_press_end", btn.btn_press, 2'b00);

        // 3: bouncing ch0
        drive(2'b10);
        edges(12);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            drive({1'b1, ((i / 3) % 2 == 0)});
            edges(1);
            pulses += int'(btn.btn_press[0]) + int'(btn.btn_release[0]);
        end
        check("t3_bounce_pulses", pulses, 0);
        drive(2'b11);
        edges(9);
        check("t3_level_early", btn.btn_level, 2'b10);
        edges(1);
        check("t3_press", btn.btn_press, 2'b01);
        check("t3_level", btn.btn_level, 2'b11);

        // 4: 7-cycle glitch on ch1
        pulses = 0;
        drive(2'b01);
        for (int i = 0; i < 7; i++) begin
            edges(1);
            pulses += $countones({btn.btn_press, btn.btn_release});
        end
        drive(2'b11);
        for (int i = 0; i < 15; i++) begin
            edges(1);
            pulses += $countones({btn.btn_press, btn.btn_release});
        end
        check("t4_glitch_pulses", pulses, 0);
        check("t4_level", btn.btn_level, 2'b11);

        // 5: simultaneous press ch0 / release ch1
        drive(2'b10);
        edges(12);
        check("t5_prep_level", btn.btn_level, 2'b10);
        drive(2'b01);
        edges(9);
        check("t5_level_early", btn.btn_level, 2'b10);
        edges(1);
        check("t5_press",   btn.btn_press,   2'b01);
        check("t5_release", btn.btn_release, 2'b10);
        check("t5_level",   btn.btn_level,   2'b01);

        // 6: reset in the middle of a count on ch1
        drive(2'b11);
        edges(7);
        rst_n = 1'b0;
        #1;
        check("t6_rst_level",   btn.btn_level,   2'b00);
        check("t6_rst_press",   btn.btn_press,   2'b00);
        check("t6_rst_release", btn.btn_release, 2'b00);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        edges(9);
        check("t6_level_early", btn.btn_level, 2'b00);
        edges(1);
        check("t6_level", btn.btn_level, 2'b11);
        check("t6_press", btn.btn_press, 2'b11);

        // Random pin activity with occasional resets, checked by the model
        for (int i = 0; i < 3000; i++) begin
            logic [NB-1:0] v;
            v = btn.btn_raw;
            for (int c = 0; c < NB; c++)
                if ($urandom_range(5) == 0) v[c] = ~v[c];
            drive(v);
            if ($urandom_range(499) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        edges(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
